// File: rtl/lagarto_plic_pkg.sv
// Shared PLIC types: interrupt IDs, gateway state encoding and default sizing.
// Gateway edge counting is enabled by the macro LAGARTO_PLIC_GW_EDGE_COUNT_EN.
package lagarto_plic_pkg;

    localparam int MXLEN = 64;

    typedef logic [MXLEN-1:0] interrupt_id_t;

    localparam interrupt_id_t NO_INTERRUPT_ID = '0;

    localparam int NUM_SOURCES = 2;
    localparam int EDGE_CNT_W  = 3;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_IN_SERVICE
    } gateway_state_t;

    // Source vector bit k carries interrupt ID k+1; ID 0 means "no interrupt".
    function automatic interrupt_id_t source_id(input int k);
        return interrupt_id_t'(k + 1);
    endfunction

endpackage

// File: rtl/lagarto_plic_gateway_cell.sv
// One interrupt source: input synchronizer, IDLE/PENDING/IN_SERVICE FSM and,
// with LAGARTO_PLIC_GW_EDGE_COUNT_EN defined, a saturating surplus-edge counter.
module lagarto_plic_gateway_cell
    import lagarto_plic_pkg::*;
#(
    parameter int EDGE_CNT_W = lagarto_plic_pkg::EDGE_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic edge_sel_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pending_o,
    output logic in_service_o
);

    if (EDGE_CNT_W < 1) begin : g_cnt_w_check
        $error("EDGE_CNT_W must be at least 1");
    end

    logic           s1_q;
    logic           s2_q;
    logic           s3_q;
    logic           rise;
    logic           trigger;
    gateway_state_t state_q;
    gateway_state_t state_d;
    logic           pending_q;
    logic           in_service_q;

    // Stage 0: two-flop synchronizer plus delay flop for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign trigger = edge_sel_i ? rise : s2_q;

`ifdef LAGARTO_PLIC_GW_EDGE_COUNT_EN
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    logic                  edge_mode_q;
    logic                  edge_mode_d;
    logic [EDGE_CNT_W-1:0] cnt_q;
    logic [EDGE_CNT_W-1:0] cnt_d;
    logic [EDGE_CNT_W-1:0] cnt_eff;

    function automatic logic [EDGE_CNT_W-1:0] sat_inc(input logic [EDGE_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // The trigger mode is latched on leaving IDLE so a later edge_sel_i change
    // cannot alter how an active request counts surplus edges.
    always_comb begin
        state_d     = state_q;
        edge_mode_d = edge_mode_q;
        cnt_eff     = cnt_q;
        if (edge_mode_q && rise && (state_q != GW_IDLE)) begin
            cnt_eff = sat_inc(cnt_q);
        end
        cnt_d = cnt_eff;
        case (state_q)
            GW_IDLE: begin
                cnt_d = '0;
                if (trigger) begin
                    state_d     = GW_PENDING;
                    edge_mode_d = edge_sel_i;
                end
            end
            GW_PENDING: begin
                if (claim_hit_i) begin
                    state_d = GW_IN_SERVICE;
                end
            end
            GW_IN_SERVICE: begin
                if (complete_hit_i) begin
                    if (cnt_eff != '0) begin
                        state_d = GW_PENDING;
                        cnt_d   = cnt_eff - 1'b1;
                    end else begin
                        state_d = GW_IDLE;
                    end
                end
            end
            default: begin
                state_d = GW_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_mode_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            edge_mode_q <= edge_mode_d;
            cnt_q       <= cnt_d;
        end
    end
`else
    // Surplus edges while a request is active are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE: begin
                if (trigger) begin
                    state_d = GW_PENDING;
                end
            end
            GW_PENDING: begin
                if (claim_hit_i) begin
                    state_d = GW_IN_SERVICE;
                end
            end
            GW_IN_SERVICE: begin
                if (complete_hit_i) begin
                    state_d = GW_IDLE;
                end
            end
            default: begin
                state_d = GW_IDLE;
            end
        endcase
    end
`endif

    // Stage 1: state register with registered output decode
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= GW_IDLE;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= (state_d == GW_PENDING);
            in_service_q <= (state_d == GW_IN_SERVICE);
        end
    end

    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: rtl/lagarto_plic_gateway.sv
// PLIC source gateway: decodes claim/complete IDs and runs one cell per source.
// Optional edge counting per source via LAGARTO_PLIC_GW_EDGE_COUNT_EN.
module lagarto_plic_gateway
    import lagarto_plic_pkg::*;
#(
    parameter int NUM_SOURCES = lagarto_plic_pkg::NUM_SOURCES,
    parameter int EDGE_CNT_W  = lagarto_plic_pkg::EDGE_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_SOURCES-1:0] irq_src_i,
    input  logic [NUM_SOURCES-1:0] edge_sel_i,
    input  logic                   claim_valid_i,
    input  interrupt_id_t          claim_id_i,
    input  logic                   complete_valid_i,
    input  interrupt_id_t          complete_id_i,
    output logic [NUM_SOURCES-1:0] pending_o,
    output logic [NUM_SOURCES-1:0] in_service_o
);

    logic [NUM_SOURCES-1:0] claim_hit;
    logic [NUM_SOURCES-1:0] complete_hit;

    // ID 0 and IDs beyond NUM_SOURCES match no bit and are silently ignored.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            claim_hit[k]    = claim_valid_i    && (claim_id_i    == source_id(k));
            complete_hit[k] = complete_valid_i && (complete_id_i == source_id(k));
        end
    end

    for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_cell
        lagarto_plic_gateway_cell #(
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_cell (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .irq_i          (irq_src_i[k]),
            .edge_sel_i     (edge_sel_i[k]),
            .claim_hit_i    (claim_hit[k]),
            .complete_hit_i (complete_hit[k]),
            .pending_o      (pending_o[k]),
            .in_service_o   (in_service_o[k])
        );
    end

endmodule

// File: tb/tb_lagarto_plic_gateway.sv
// Self-checking bench for lagarto_plic_gateway: vector table plus hand-written
// sequences, expected outputs queued at drive time and compared after the edge.
module tb_lagarto_plic_gateway;
    import lagarto_plic_pkg::*;

`ifdef LAGARTO_PLIC_GW_EDGE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    irq_src;
    logic [1:0]    edge_sel;
    logic          claim_valid;
    interrupt_id_t claim_id;
    logic          complete_valid;
    interrupt_id_t complete_id;
    logic [1:0]    pending;
    logic [1:0]    in_service;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] irq;
        logic [1:0] esel;
        logic       cv;
        int         cid;
        logic       pv;
        int         pid;
        logic [1:0] exp_p;
        logic [1:0] exp_s;
        string      tag;
    } vec_t;

    typedef struct {
        logic [1:0] p;
        logic [1:0] s;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    lagarto_plic_gateway dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .irq_src_i        (irq_src),
        .edge_sel_i       (edge_sel),
        .claim_valid_i    (claim_valid),
        .claim_id_i       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
        .pending_o        (pending),
        .in_service_o     (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check2(input string tag, input logic [1:0] act, input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", tag, act, req);
        end
    endtask

    function automatic void add(input logic [1:0] irq, input logic [1:0] esel,
                                input logic cv, input int cid, input logic pv, input int pid,
                                input logic [1:0] ep, input logic [1:0] es, input string tag);
        tbl.push_back('{irq: irq, esel: esel, cv: cv, cid: cid, pv: pv, pid: pid,
                        exp_p: ep, exp_s: es, tag: tag});
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare one step after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        irq_src        = v.irq;
        edge_sel       = v.esel;
        claim_valid    = v.cv;
        claim_id       = interrupt_id_t'(v.cid);
        complete_valid = v.pv;
        complete_id    = interrupt_id_t'(v.pid);
        sb.push_back('{p: v.exp_p, s: v.exp_s, tag: v.tag});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", v.tag);
        end else begin
            e = sb.pop_front();
            check2({e.tag, " pending"}, pending, e.p);
            check2({e.tag, " in_service"}, in_service, e.s);
        end
    endtask

    task automatic step(input logic [1:0] irq, input logic [1:0] esel,
                        input logic cv, input int cid, input logic pv, input int pid,
                        input logic [1:0] ep, input logic [1:0] es, input string tag);
        vec_t v;
        v = '{irq: irq, esel: esel, cv: cv, cid: cid, pv: pv, pid: pid,
              exp_p: ep, exp_s: es, tag: tag};
        apply(v);
    endtask

    initial begin
        // Level JTAG0: pend on edge 3, claim, complete with line high re-pends after one idle cycle
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "lvl sync1");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "lvl sync2");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, "lvl pend");
        add(2'b01, 2'b00, 1, 1, 0, 0, 2'b00, 2'b01, "lvl claim");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, "lvl hold");
        add(2'b01, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, "lvl complete");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, "lvl repend");
        add(2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b01, "lvl claim2");
        add(2'b00, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, "lvl complete2");
        add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "lvl quiet");
        // Edge JTAG1: single pulse, claim, complete, no re-pend
        add(2'b10, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, "edge pulse");
        add(2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, "edge sync");
        add(2'b00, 2'b10, 0, 0, 0, 0, 2'b10, 2'b00, "edge pend");
        add(2'b00, 2'b10, 1, 2, 0, 0, 2'b00, 2'b10, "edge claim");
        add(2'b00, 2'b10, 0, 0, 1, 2, 2'b00, 2'b00, "edge complete");
        add(2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, "edge no repend1");
        add(2'b00, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, "edge no repend2");
        // Illegal IDs against a pending source 0
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "ill sync1");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "ill sync2");
        add(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, "ill pend");
        add(2'b01, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, "ill claim id0");
        add(2'b01, 2'b00, 1, 3, 0, 0, 2'b01, 2'b00, "ill claim id3");
        add(2'b01, 2'b00, 1, 2, 0, 0, 2'b01, 2'b00, "ill claim idle src1");
        add(2'b01, 2'b00, 0, 0, 1, 1, 2'b01, 2'b00, "ill complete pending");
        add(2'b01, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, "ill complete id0");
        add(2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b01, "ill cleanup claim");
        add(2'b00, 2'b00, 0, 0, 1, 3, 2'b00, 2'b01, "ill complete id3");
        add(2'b00, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, "ill cleanup complete");
        add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "ill quiet");
        // Simultaneous complete ID 1 and claim ID 2
        add(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "sim sync1");
        add(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "sim sync2");
        add(2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, "sim pend both");
        add(2'b00, 2'b00, 1, 1, 0, 0, 2'b10, 2'b01, "sim claim1");
        add(2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 2'b01, "sim hold");
        add(2'b00, 2'b00, 1, 2, 1, 1, 2'b00, 2'b10, "sim both");
        add(2'b00, 2'b00, 0, 0, 1, 2, 2'b00, 2'b00, "sim complete2");
        add(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "sim quiet");

        rst            = 1'b1;
        irq_src        = '0;
        edge_sel       = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        repeat (2) @(posedge clk);
        #1;
        check2("reset pending", pending, 2'b00);
        check2("reset in_service", in_service, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset while source 0 is pending
        step(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "rst sync1");
        step(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "rst sync2");
        step(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, "rst pend");
        #2;
        rst     = 1'b1;
        irq_src = 2'b00;
        #1;
        check2("rst async pending", pending, 2'b00);
        check2("rst async in_service", in_service, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, "rst after release");
        end

        // Edge source 0: nine pulses while in service saturate the surplus counter
        step(2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, "cnt pulse");
        step(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, "cnt sync");
        step(2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, "cnt pend");
        step(2'b00, 2'b01, 1, 1, 0, 0, 2'b00, 2'b01, "cnt claim");
        for (int p = 0; p < 9; p++) begin
            step(2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, "cnt burst hi");
            step(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, "cnt burst lo");
        end
        step(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, "cnt settle1");
        step(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b01, "cnt settle2");
        for (int i = 0; i < 7; i++) begin
            step(2'b00, 2'b01, 0, 0, 1, 1, CNT_EN ? 2'b01 : 2'b00, 2'b00, "cnt complete repend");
            step(2'b00, 2'b01, 1, 1, 0, 0, 2'b00, CNT_EN ? 2'b01 : 2'b00, "cnt reclaim");
        end
        step(2'b00, 2'b01, 0, 0, 1, 1, 2'b00, 2'b00, "cnt final complete");
        step(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, "cnt idle");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
